jpeg_lift: RTL and testbench

JPEG_LIFT -- requirements
Module: jpeg_lift

---
 rtl/jpeg_lift.sv | 98 +++++++++
 tb/tb_jpeg_lift.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_lift.sv
// rtl/jpeg_lift.sv - two-stage 5/3 integer lifting step (predict/update, forward/inverse) with saturation
module jpeg_lift #(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vld_i,
    input  logic signed [W-1:0] l_s,
    input  logic signed [W-1:0] r_s,
    input  logic signed [W-1:0] s_s,
    input  logic                e_o_s,
    input  logic                f_i_s,
    output logic signed [W-1:0] res_s,
    output logic                vld_o,
    output logic                sat_o
);

    localparam int IW = W + 2;

    localparam logic signed [IW-1:0] MAX_V = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [IW-1:0] MIN_V = {3'b111, {(W-1){1'b0}}};

    // Stage 1 state
    logic                 vld1_q;
    logic signed [IW-1:0] sum1_q;
    logic signed [W-1:0]  s1_q;
    logic                 e1_q;
    logic                 f1_q;

    logic signed [IW-1:0] l_ext;
    logic signed [IW-1:0] r_ext;
    logic signed [IW-1:0] bias;
    logic signed [IW-1:0] sum_d;

    assign l_ext = {{2{l_s[W-1]}}, l_s};
    assign r_ext = {{2{r_s[W-1]}}, r_s};
    // The update step rounds (l+r)/4 to nearest by pre-adding 2 before the shift
    assign bias  = e_o_s ? IW'(0) : IW'(2);
    assign sum_d = l_ext + r_ext + bias;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld1_q <= 1'b0;
            sum1_q <= '0;
            s1_q   <= '0;
            e1_q   <= 1'b0;
            f1_q   <= 1'b0;
        end else begin
            vld1_q <= vld_i;
            if (vld_i) begin
                sum1_q <= sum_d;
                s1_q   <= s_s;
                e1_q   <= e_o_s;
                f1_q   <= f_i_s;
            end
        end
    end

    // Stage 2 datapath
    logic signed [IW-1:0] s_ext;
    logic signed [IW-1:0] shifted;
    logic signed [IW-1:0] wide;
    logic signed [W-1:0]  clamped;
    logic                 sat_d;

    assign s_ext   = {{2{s1_q[W-1]}}, s1_q};
    // Arithmetic shift gives floor division (toward minus infinity)
    assign shifted = e1_q ? (sum1_q >>> 1) : (sum1_q >>> 2);
    // Forward predict and inverse update subtract; the other two add
    assign wide    = (e1_q == f1_q) ? (s_ext - shifted) : (s_ext + shifted);

    always_comb begin
        clamped = wide[W-1:0];
        sat_d   = 1'b0;
        if (wide > MAX_V) begin
            clamped = MAX_V[W-1:0];
            sat_d   = 1'b1;
        end else if (wide < MIN_V) begin
            clamped = MIN_V[W-1:0];
            sat_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_s <= '0;
            vld_o <= 1'b0;
            sat_o <= 1'b0;
        end else begin
            vld_o <= vld1_q;
            sat_o <= vld1_q & sat_d;
            if (vld1_q) begin
                res_s <= clamped;
            end
        end
    end

endmodule

// File: tb/tb_jpeg_lift.sv
// tb/tb_jpeg_lift.sv - randomized self-checking bench for jpeg_lift against an integer reference model
module tb_jpeg_lift;

    logic               clk;
    logic               rst_n;
    logic               vld_i;
    logic signed [15:0] l_s;
    logic signed [15:0] r_s;
    logic signed [15:0] s_s;
    logic               e_o_s;
    logic               f_i_s;
    logic signed [15:0] res_s;
    logic               vld_o;
    logic               sat_o;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    jpeg_lift #(.W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vld_i (vld_i),
        .l_s   (l_s),
        .r_s   (r_s),
        .s_s   (s_s),
        .e_o_s (e_o_s),
        .f_i_s (f_i_s),
        .res_s (res_s),
        .vld_o (vld_o),
        .sat_o (sat_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int fdiv(input int a, input int d);
        int q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int lift_raw(input int l, input int r, input int s, input logic e, input logic f);
        if (e) return f ? s - fdiv(l + r, 2) : s + fdiv(l + r, 2);
        else   return f ? s + fdiv(l + r + 2, 4) : s - fdiv(l + r + 2, 4);
    endfunction

    function automatic int clamp16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic logic is_sat(input int v);
        return (v > 32767) || (v < -32768);
    endfunction

    task automatic rand_data();
        l_s   = 16'($urandom);
        r_s   = 16'($urandom);
        s_s   = 16'($urandom);
        e_o_s = 1'($urandom);
        f_i_s = 1'($urandom);
    endtask

    // Presents one input, then idles with scrambled data; returns outputs two cycles later
    task automatic run_one(input int l, input int r, input int s, input logic e, input logic f,
                           output logic signed [15:0] res, output logic vo, output logic so);
        l_s = 16'(l); r_s = 16'(r); s_s = 16'(s); e_o_s = e; f_i_s = f;
        vld_i = 1'b1;
        @(posedge clk); #1;
        vld_i = 1'b0;
        rand_data();
        @(posedge clk); #1;
        res = res_s; vo = vld_o; so = sat_o;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vld_i = 1'b0; rand_data();
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++;
        if (res_s !== 16'sd0 || vld_o !== 1'b0 || sat_o !== 1'b0)
            $display("FAIL reset_state: got res=%0d vld=%b sat=%b required res=0 vld=0 sat=0", res_s, vld_o, sat_o);
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_forward_predict();
        logic signed [15:0] res; logic vo, so;
        run_one(10, 20, 100, 1'b1, 1'b1, res, vo, so);
        chk_cnt++;
        if (res !== 16'sd85) $display("FAIL fwd_predict_res: got %0d required 85", res); else pass_cnt++;
        chk_cnt++;
        if (vo !== 1'b1 || so !== 1'b0) $display("FAIL fwd_predict_flags: got vld=%b sat=%b required vld=1 sat=0", vo, so); else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++;
        if (vld_o !== 1'b0 || sat_o !== 1'b0) $display("FAIL single_pulse: got vld=%b sat=%b required 0 0", vld_o, sat_o); else pass_cnt++;
        chk_cnt++;
        if (res_s !== 16'sd85) $display("FAIL res_hold: got %0d required 85", res_s); else pass_cnt++;
    endtask

    task automatic test_modes();
        logic signed [15:0] res; logic vo, so;
        int expv [3] = '{115, 108, 92};
        logic em [3] = '{1'b1, 1'b0, 1'b0};
        logic fm [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            run_one(10, 20, 100, em[i], fm[i], res, vo, so);
            chk_cnt++;
            if (res !== 16'(expv[i]) || vo !== 1'b1 || so !== 1'b0)
                $display("FAIL mode_e%0b_f%0b: got res=%0d vld=%b sat=%b required res=%0d vld=1 sat=0",
                         em[i], fm[i], res, vo, so, expv[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_round_trip();
        logic signed [15:0] fwd, inv; logic vo, so;
        int l, r, s;
        logic e;
        for (int i = 0; i < 4; i++) begin
            l = $urandom_range(0, 16000) - 8000;
            r = $urandom_range(0, 16000) - 8000;
            s = $urandom_range(0, 16000) - 8000;
            e = 1'(i);
            run_one(l, r, s, e, 1'b1, fwd, vo, so);
            run_one(l, r, int'(fwd), e, 1'b0, inv, vo, so);
            chk_cnt++;
            if (inv !== 16'(s)) $display("FAIL round_trip_e%0b: got %0d required %0d", e, inv, s); else pass_cnt++;
        end
    endtask

    task automatic test_neg_rounding();
        logic signed [15:0] res; logic vo, so;
        run_one(-3, 0, 0, 1'b1, 1'b1, res, vo, so);
        chk_cnt++;
        if (res !== 16'sd2) $display("FAIL neg_rounding: got %0d required 2", res); else pass_cnt++;
    endtask

    task automatic test_saturation();
        logic signed [15:0] res; logic vo, so;
        run_one(-32768, -32768, 32767, 1'b1, 1'b1, res, vo, so);
        chk_cnt++;
        if (res !== 16'sd32767 || so !== 1'b1 || vo !== 1'b1)
            $display("FAIL sat_high: got res=%0d sat=%b vld=%b required res=32767 sat=1 vld=1", res, so, vo);
        else pass_cnt++;
        run_one(32767, 32767, -32768, 1'b0, 1'b0, res, vo, so);
        chk_cnt++;
        if (res !== -16'sd32768 || so !== 1'b1 || vo !== 1'b1)
            $display("FAIL sat_low: got res=%0d sat=%b vld=%b required res=-32768 sat=1 vld=1", res, so, vo);
        else pass_cnt++;
    endtask

    // pat bit k=1 presents a random input in cycle k; outputs checked one loop iteration later
    task automatic test_stream(input logic [15:0] pat, input int n, input string name);
        logic signed [15:0] exp_res [16];
        logic               exp_sat [16];
        logic signed [15:0] last;
        logic               have_last;
        int                 raw;
        have_last = 1'b0;
        last = '0;
        for (int c = 0; c <= n; c++) begin
            if (c < n) begin
                rand_data();
                vld_i = pat[c];
                raw = lift_raw(int'(l_s), int'(r_s), int'(s_s), e_o_s, f_i_s);
                exp_res[c] = 16'(clamp16(raw));
                exp_sat[c] = is_sat(raw);
            end else begin
                vld_i = 1'b0;
            end
            @(posedge clk); #1;
            if (c >= 1) begin
                if (pat[c-1]) begin
                    chk_cnt++;
                    if (vld_o !== 1'b1 || res_s !== exp_res[c-1] || sat_o !== exp_sat[c-1])
                        $display("FAIL %s_item%0d: got res=%0d vld=%b sat=%b required res=%0d vld=1 sat=%b",
                                 name, c-1, res_s, vld_o, sat_o, exp_res[c-1], exp_sat[c-1]);
                    else pass_cnt++;
                    last = exp_res[c-1];
                    have_last = 1'b1;
                end else begin
                    chk_cnt++;
                    if (vld_o !== 1'b0 || sat_o !== 1'b0 || (have_last && res_s !== last))
                        $display("FAIL %s_gap%0d: got res=%0d vld=%b sat=%b required res=%0d vld=0 sat=0",
                                 name, c-1, res_s, vld_o, sat_o, last);
                    else pass_cnt++;
                end
            end
        end
        vld_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        test_stream(16'h00FF, 8, "stream8");
    endtask

    task automatic test_gap();
        test_stream(16'b0000_0011_0111_0111, 10, "stream_gap");
    endtask

    task automatic test_reset_mid_stream();
        logic signed [15:0] res; logic vo, so;
        l_s = 16'sd10; r_s = 16'sd20; s_s = 16'sd100; e_o_s = 1'b1; f_i_s = 1'b0;
        vld_i = 1'b1;
        @(posedge clk); #1;
        s_s = 16'sd200;
        @(posedge clk); #1;
        vld_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (res_s !== 16'sd0 || vld_o !== 1'b0 || sat_o !== 1'b0)
            $display("FAIL mid_reset_async: got res=%0d vld=%b sat=%b required 0 0 0", res_s, vld_o, sat_o);
        else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk_cnt++;
            if (vld_o !== 1'b0 || res_s !== 16'sd0)
                $display("FAIL stale_after_reset%0d: got vld=%b res=%0d required vld=0 res=0", c, vld_o, res_s);
            else pass_cnt++;
        end
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        run_one(10, 20, 100, 1'b0, 1'b1, res, vo, so);
        chk_cnt++;
        if (res !== 16'sd108 || vo !== 1'b1)
            $display("FAIL first_after_release: got res=%0d vld=%b required res=108 vld=1", res, vo);
        else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0;
        vld_i = 1'b0;
        l_s = '0; r_s = '0; s_s = '0; e_o_s = 1'b0; f_i_s = 1'b0;
        test_reset();
        test_forward_predict();
        test_modes();
        test_round_trip();
        test_neg_rounding();
        test_saturation();
        test_back_to_back();
        test_gap();
        test_reset_mid_stream();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
